// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: 4-channel bit-interleaved TDM receiver with frame alignment and word assembly
module tdm_demux_1to4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               frame_start,
  output logic [4*WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic               locked,
  output logic               sync_err
);
  localparam int FW = $clog2(WIDTH);
  typedef enum logic {HUNT, RUN} state_t;
  state_t                  state;
  logic [1:0]              slot;
  logic [FW-1:0]           frame_cnt;
  logic [3:0][WIDTH-1:0]   sr, sr_nx;
  logic                    realign, last;
  always_comb begin
    sr_nx = sr;
    sr_nx[slot] = {sr[slot][WIDTH-2:0], din};
  end
  // a new word starts on the first frame_start in HUNT, or on a misplaced one in RUN
  assign realign = frame_start && (state == HUNT || slot != 2'd0);
  assign last    = slot == 2'd3 && frame_cnt == FW'(WIDTH - 1);
  assign locked  = state == RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= '0;
      frame_cnt  <= '0;
      sr         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      if (din_valid && realign) begin
        sync_err  <= state == RUN;
        state     <= RUN;
        sr        <= {{(4*WIDTH-1){1'b0}}, din};
        slot      <= 2'd1;
        frame_cnt <= '0;
      end else if (din_valid && state == RUN) begin
        sr   <= sr_nx;
        slot <= slot + 2'd1;
        if (slot == 2'd3)
          frame_cnt <= last ? '0 : frame_cnt + FW'(1);
        if (last) begin
          dout       <= sr_nx;
          dout_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/tdm_demux_1to4.md
# tdm_demux_1to4

Time-division demultiplexer: the receive end of a 4-channel bit-interleaved link whose transmit side cycles a 4:1 selector over channels 0..3. Takes one serial bit per valid beat, aligns to a frame-start strobe, steers each bit to its channel's shift register, and presents four WIDTH-bit words together once WIDTH complete frames have been received. Sits between the serial link front-end and the per-channel parallel consumers.

## Interface
- WIDTH, 8, bits per channel word; legal range 2..32.
- clk  input  1  rising-edge clock for all logic.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is a valid beat this cycle.
- frame_start  input  1  qualifies the current beat as slot 0 (channel 0); ignored when din_valid=0.
- dout  output  4*WIDTH  channel words; channel n at dout[n*WIDTH +: WIDTH].
- dout_valid  output  1  one-cycle pulse: dout updated with a new complete word set.
- locked  output  1  high while frame alignment is held (state RUN).
- sync_err  output  1  one-cycle pulse: frame_start arrived at a slot other than 0 while locked.

## Operation
- Reset (synchronous, active-high): state=HUNT, slot=0, frame_cnt=0, all four shift registers=0, dout=0, dout_valid=0, locked=0, sync_err=0. Reset wins over every other event in the same cycle, including mid-word; partial data is discarded.
- State HUNT: beats without frame_start are discarded. Beat with frame_start: din stored as channel 0 bit, slot←1, frame_cnt←0, state←RUN.
- State RUN, per valid beat without frame_start: din shifted into channel[slot] register (shift left, new bit at LSB; first bit received ends up at MSB); slot←slot+1 mod 4.
- Frame completes on the slot-3 beat: frame_cnt←frame_cnt+1, wrapping to 0 after WIDTH-1.
- Word completes on the slot-3 beat with frame_cnt=WIDTH-1: next cycle dout holds all four registers including that bit, dout_valid=1.
- frame_start at slot 0 in RUN: normal beat, no error.
- frame_start at slot≠0 in RUN: sync_err=1 next cycle; partial word dropped (shift registers cleared, frame_cnt←0); this beat stored as channel 0 bit of a new word, slot←1; state stays RUN. dout/dout_valid unaffected.
- Absent frame_start, slot wraps 3→0 freely; alignment is kept.
- din_valid=0: all state, counters and registers hold; gaps of any length are legal anywhere in a frame.
- dout holds its value until the next completed word set or reset.
- locked=1 exactly when state=RUN; RUN is left only by reset.

## Timing
- All outputs registered; no combinational input→output paths.
- Latency: last bit of a word set on beat at cycle k → dout/dout_valid visible at cycle k+1.
- dout_valid and sync_err are single-cycle pulses; never high in consecutive cycles from one event.
- locked rises the cycle after the first accepted frame_start beat.
- Minimum word-set period: 4*WIDTH cycles at full rate (din_valid held high); back-to-back word sets produce dout_valid pulses exactly 4*WIDTH cycles apart.

## Test plan
- Reset, then 10 beats with frame_start=0 → locked=0, dout_valid never asserts, dout=0.
- WIDTH=8, continuous beats, frame_start on first beat only, ch0..ch3 words 0xA5,0x3C,0xFF,0x01 interleaved MSB first (32 beats) → dout_valid one cycle after beat 32, dout={0x01,0xFF,0x3C,0xA5}.
- Same stream with random din_valid gaps (1-5 idle cycles) → identical dout, dout_valid one cycle after last beat.
- Two back-to-back word sets (second 0x00,0x11,0x22,0x33, frame_start each frame) → dout_valid pulses 32 cycles apart, each dout correct, no sync_err.
- frame_start injected at slot 2 of frame 3 → sync_err pulse, no dout_valid for dropped set; next 32 beats from that point yield the correct words.
- rst asserted at beat 20 of a word set → all outputs 0 next cycle, locked=0; subsequent aligned stream decodes correctly.
